// File: rtl/uart_pkt_parser.sv
// Packet parser behind the UART receiver: hunts SOF, buffers CMD/LEN/PAYLOAD, verifies XOR checksum, streams payload.
// Optional inter-byte timeout is compiled in with `define UART_PKT_TIMEOUT_EN.
module uart_pkt_parser #(
  parameter int          MAX_LEN     = 16,
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter int          TIMEOUT_CYC = 17360,
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  input  logic          rx_ferr,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [7:0]    pkt_cmd,
  output logic [LW-1:0] pkt_len,
  output logic          pkt_done,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_frame,
  output logic          err_timeout,
  output logic [7:0]    drop_cnt
);

  localparam int         IW        = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cmd_r, chk;
  logic [LW-1:0] len_r, idx, rd_idx, len_m1, rd_nxt;
  logic [7:0]    buf_mem [MAX_LEN];
  logic          byte_ok, ferr_hit, in_pkt, handshake, timeout_hit;
  logic          len_bad, chk_good, chk_bad;

  assign byte_ok   = rx_valid & ~rx_ferr;
  assign ferr_hit  = rx_valid & rx_ferr;
  assign in_pkt    = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign handshake = out_valid & out_ready;
  assign len_m1    = len_r - LW'(1);
  assign rd_nxt    = rd_idx + LW'(1);

`ifdef UART_PKT_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Any byte restarts the idle count; only partially received packets can time out.
  always_ff @(posedge clk) begin
    if (!rstn || rx_valid || !in_pkt || timeout_hit) tmo_cnt <= '0;
    else                                             tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign timeout_hit = in_pkt && !rx_valid && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYC != 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    len_bad   = 1'b0;
    chk_good  = 1'b0;
    chk_bad   = 1'b0;
    case (state)
      HUNT:    if (byte_ok && rx_byte == SOF) state_nxt = CMD;
      CMD:     if (byte_ok) state_nxt = LEN;
      LEN: begin
        if (byte_ok) begin
          if (rx_byte > MAX_LEN_B) begin
            len_bad   = 1'b1;
            state_nxt = HUNT;
          end else if (rx_byte == 8'd0) begin
            state_nxt = CHK;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: if (byte_ok && idx == len_m1) state_nxt = CHK;
      CHK: begin
        if (byte_ok) begin
          if (rx_byte == chk) begin
            chk_good  = 1'b1;
            state_nxt = (len_r == '0) ? HUNT : DRAIN;
          end else begin
            chk_bad   = 1'b1;
            state_nxt = HUNT;
          end
        end
      end
      DRAIN:   if (handshake && out_last) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
    if (in_pkt && (ferr_hit || timeout_hit)) state_nxt = HUNT;
  end

  always_ff @(posedge clk) begin
    if (state == PAYLOAD && byte_ok) buf_mem[idx[IW-1:0]] <= rx_byte;
  end

  // Output beats are loaded one step ahead so data/last stay registered and stable under stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_r       <= '0;
      chk         <= '0;
      len_r       <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      pkt_cmd     <= '0;
      pkt_len     <= '0;
      pkt_done    <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      pkt_done    <= 1'b0;
      err_chk     <= chk_bad;
      err_len     <= len_bad;
      err_frame   <= in_pkt & ferr_hit;
      err_timeout <= timeout_hit;
      case (state)
        CMD: if (byte_ok) begin
          cmd_r <= rx_byte;
          chk   <= rx_byte;
        end
        LEN: if (byte_ok && !len_bad) begin
          len_r <= rx_byte[LW-1:0];
          chk   <= chk ^ rx_byte;
          idx   <= '0;
        end
        PAYLOAD: if (byte_ok) begin
          chk <= chk ^ rx_byte;
          idx <= idx + LW'(1);
        end
        CHK: if (chk_good) begin
          pkt_cmd <= cmd_r;
          pkt_len <= len_r;
          if (len_r == '0) begin
            pkt_done <= 1'b1;
          end else begin
            rd_idx    <= '0;
            out_valid <= 1'b1;
            out_data  <= buf_mem[0];
            out_last  <= (len_r == LW'(1));
          end
        end
        DRAIN: begin
          if (rx_valid && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (handshake) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              pkt_done  <= 1'b1;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= buf_mem[rd_nxt[IW-1:0]];
              out_last <= (rd_nxt == len_m1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: packet-level scoreboard of expected beats and pulse counts.
// Builds with or without UART_PKT_TIMEOUT_EN.
module tb_uart_pkt_parser;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_ferr = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last, pkt_done, err_chk, err_len, err_frame, err_timeout;
  logic [7:0] out_data, pkt_cmd, drop_cnt;
  logic [4:0] pkt_len;

  always #5 clk = ~clk;

  uart_pkt_parser dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ferr(rx_ferr),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pkt_cmd(pkt_cmd), .pkt_len(pkt_len), .pkt_done(pkt_done), .err_chk(err_chk),
    .err_len(err_len), .err_frame(err_frame), .err_timeout(err_timeout), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q [$];
  logic [7:0] pl [16];
  int n_done = 0, n_chk = 0, n_len = 0, n_frame = 0, n_tmo = 0;
  int exp_done = 0, exp_chk = 0, exp_len = 0, exp_frame = 0, exp_tmo = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_chk(input logic [7:0] cmd, input int len);
    logic [7:0] x;
    x = cmd ^ 8'(len);
    for (int i = 0; i < len; i++) x = x ^ pl[i];
    return x;
  endfunction

  task automatic push_expected(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pl[i]});
    exp_done++;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic ferr);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    rx_ferr  = ferr;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] cmd, input int len, input logic [7:0] flip);
    logic [7:0] c;
    c = model_chk(cmd, len) ^ flip;
    if (flip == 8'h00) push_expected(len);
    else               exp_chk++;
    apply_stimulus(8'hA5, 1'b0);
    apply_stimulus(cmd, 1'b0);
    apply_stimulus(8'(len), 1'b0);
    for (int i = 0; i < len; i++) apply_stimulus(pl[i], 1'b0);
    apply_stimulus(c, 1'b0);
  endtask

  task automatic wait_idle(input string name, input int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL %s: drain bound expired, pending beats %0d, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check_output({tag, "_done"},  32'(n_done),  32'(exp_done));
    check_output({tag, "_chk"},   32'(n_chk),   32'(exp_chk));
    check_output({tag, "_len"},   32'(n_len),   32'(exp_len));
    check_output({tag, "_frame"}, 32'(n_frame), 32'(exp_frame));
    check_output({tag, "_tmo"},   32'(n_tmo),   32'(exp_tmo));
  endtask

  // Every valid beat must match the head of the scoreboard, whether or not it is accepted.
  always @(negedge clk) begin
    int s;
    logic [8:0] e;
    if (rstn) begin
      n_done  += int'(pkt_done);
      n_chk   += int'(err_chk);
      n_len   += int'(err_len);
      n_frame += int'(err_frame);
      n_tmo   += int'(err_timeout);
      s = int'(err_chk) + int'(err_len) + int'(err_frame) + int'(err_timeout);
      if (s != 0) check_output("err_onehot", 32'(s), 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
        end else begin
          e = exp_q[0];
          check_output("beat_data", 32'(out_data), 32'(e[7:0]));
          check_output("beat_last", 32'(out_last), 32'(e[8]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_data",  32'(out_data),  32'd0);
    check_output("rst_last",  32'(out_last),  32'd0);
    check_output("rst_cmd",   32'(pkt_cmd),   32'd0);
    check_output("rst_len",   32'(pkt_len),   32'd0);
    check_output("rst_drop",  32'(drop_cnt),  32'd0);
    check_output("rst_pulses", 32'({pkt_done, err_chk, err_len, err_frame, err_timeout}), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Case 1: good 3-byte packet, consumer always ready
    for (int i = 0; i < 16; i++) pl[i] = 8'(17 * (i + 1));
    check_output("model_chk_pin", 32'(model_chk(8'h01, 3)), 32'h02);
    out_ready = 1'b1;
    send_packet(8'h01, 3, 8'h00);
    @(negedge clk);
    check_output("t1_latency_valid", 32'(out_valid), 32'd1);
    check_output("t1_first_data",    32'(out_data),  32'h11);
    wait_idle("t1_drain", 20);
    check_output("t1_cmd", 32'(pkt_cmd), 32'h01);
    check_output("t1_len", 32'(pkt_len), 32'd3);
    check_counts("t1");

    // Case 2: bad checksums leave the last good CMD/LEN untouched
    send_packet(8'h01, 3, 8'h01);
    pl[0] = 8'h44;
    send_packet(8'h09, 1, 8'h01);
    pl[0] = 8'h11;
    wait_idle("t2_idle", 10);
    check_output("t2_cmd", 32'(pkt_cmd), 32'h01);
    check_output("t2_len", 32'(pkt_len), 32'd3);
    check_counts("t2");

    // Case 3: oversize LEN, zero-length packet, then a maximum-length packet under a stuttering consumer
    apply_stimulus(8'h00, 1'b0);
    apply_stimulus(8'hFF, 1'b0);
    apply_stimulus(8'hA5, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    apply_stimulus(8'h11, 1'b0);
    exp_len++;
    send_packet(8'h07, 0, 8'h00);
    wait_idle("t3_zero", 10);
    check_output("t3_cmd", 32'(pkt_cmd), 32'h07);
    check_output("t3_len", 32'(pkt_len), 32'd0);
    check_counts("t3a");
    send_packet(8'h3C, 16, 8'h00);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      out_ready = (i % 3 != 0);
    end
    out_ready = 1'b1;
    wait_idle("t3_max", 40);
    check_output("t3_max_cmd", 32'(pkt_cmd), 32'h3C);
    check_output("t3_max_len", 32'(pkt_len), 32'd16);
    check_counts("t3b");

    // Case 4: stalled output while the UART keeps delivering bytes
    out_ready = 1'b0;
    send_packet(8'h01, 3, 8'h00);
    apply_stimulus(8'h55, 1'b0);
    apply_stimulus(8'h66, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_output("t4_hold_valid", 32'(out_valid), 32'd1);
    check_output("t4_hold_data",  32'(out_data),  32'h11);
    check_output("t4_drop2",      32'(drop_cnt),  32'd2);
    for (int i = 0; i < 300; i++) apply_stimulus(8'(i), 1'b0);
    @(negedge clk);
    check_output("t4_drop_sat", 32'(drop_cnt), 32'd255);
    out_ready = 1'b1;
    wait_idle("t4_drain", 20);
    check_counts("t4");

    // Case 5: framing error mid-packet, recovery, then reset during DRAIN
    apply_stimulus(8'hA5, 1'b0);
    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    apply_stimulus(8'h11, 1'b1);
    exp_frame++;
    send_packet(8'h01, 3, 8'h00);
    wait_idle("t5_recover", 20);
    check_counts("t5a");
    out_ready = 1'b0;
    send_packet(8'h01, 3, 8'h00);
    @(negedge clk);
    check_output("t5_in_drain", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_q.delete();
    exp_done--;
    @(posedge clk);
    @(negedge clk);
    check_output("t5_rst_valid", 32'(out_valid), 32'd0);
    check_output("t5_rst_drop",  32'(drop_cnt),  32'd0);
    check_output("t5_rst_cmd",   32'(pkt_cmd),   32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    send_packet(8'h01, 3, 8'h00);
    wait_idle("t5_after_rst", 20);
    check_output("t5_cmd", 32'(pkt_cmd), 32'h01);
    check_counts("t5b");

    // Case 6: long idle gap inside a packet
    apply_stimulus(8'hA5, 1'b0);
    apply_stimulus(8'h01, 1'b0);
    repeat (17400) @(posedge clk);
`ifdef UART_PKT_TIMEOUT_EN
    exp_tmo++;
    send_packet(8'h01, 3, 8'h00);
`else
    push_expected(3);
    apply_stimulus(8'h03, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(pl[i], 1'b0);
    apply_stimulus(8'h02, 1'b0);
`endif
    wait_idle("t6_drain", 20);
    check_counts("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
